lcd_timing_monitor: RTL and testbench
=====================================

LCD_TIMING_MONITOR -- requirements
Module: lcd_timing_monitor

Interface
REQ-001 Parameter EXP_H, default 480: expected active pixels per line (DE-high run length).
REQ-002 Parameter EXP_V, default 272: expected active lines per frame.
REQ-003 Parameter VGAP_MIN, default 1000: DE-low run length, in cycles, that marks vertical blanking; must exceed the longest horizontal blank.
REQ-004 Parameter LOCK_FRAMES, default 2: consecutive good frames required to assert Locked.
REQ-005 PixelClk  in  1: pixel clock; all state changes on its rising edge.
REQ-006 nRST  in  1: reset; one clock, asynchronous and active-low.
REQ-007 LCD_DE  in  1: data enable of the incoming SYNC-DE video stream.
REQ-008 LCD_R / LCD_G / LCD_B  in  5/6/5: pixel colour; sampled only while LCD_DE=1.
REQ-009 HActive  out  16: DE-high width of the last line of the most recent frame.
REQ-010 VActive  out  16: line count of the most recent frame.
REQ-011 FrameDone  out  1: one-cycle pulse at each detected frame end.
REQ-012 FrameErr  out  1: one-cycle pulse, coincident with FrameDone, when the frame is bad.
REQ-013 Locked  out  1: level; timing matches expectations.
REQ-014 FrameCount  out  8: count of FrameDone pulses since reset.
REQ-015 PixelCrc  out  16: CRC of the most recent frame's active pixels.

Function
REQ-016 The FSM SHALL have states SEARCH, V_BLANK, LINE, H_BLANK.
- SEARCH: entered after reset; DE ignored.
- SEARCH -> V_BLANK: gap counter reaches VGAP_MIN. No FrameDone on this transition.
REQ-017 The gap counter SHALL increment on each DE=0 cycle and clear on DE=1.
- Saturates at VGAP_MIN.
REQ-018 Line start: V_BLANK or H_BLANK with DE=1 -> LINE.
- Pixel counter loads 1.
- Line counter increments.
- From V_BLANK only, the line counter first clears, so the first line counts as 1.
REQ-019 LINE with DE=1: pixel counter increments, 16-bit, saturating at 0xFFFF.
REQ-020 LINE with DE=0 -> H_BLANK; the completed width is stored.
- A width mismatch flag is set if this width differs from EXP_H.
- The flag clears at each frame start.
REQ-021 H_BLANK with gap counter reaching VGAP_MIN -> V_BLANK. In the same cycle:
- FrameDone pulses.
- HActive loads the stored width; VActive loads the line count.
- FrameCount increments, wrapping 255 -> 0.
REQ-022 Frame good: line count == EXP_V and mismatch flag clear; otherwise FrameErr pulses with FrameDone.
REQ-023 The line counter SHALL be 16-bit, saturating at 0xFFFF.
REQ-024 The good-frame counter SHALL:
- increment on each good frame, saturating at LOCK_FRAMES;
- clear on a bad frame.
- Locked = (good-frame counter == LOCK_FRAMES).
- Locked drops in the FrameDone cycle of the first bad frame.
REQ-025 Outputs SHALL be registered; FrameDone fires one cycle after the DE sample that completes the gap.

Reset
REQ-026 While nRST=0, all outputs SHALL read 0 and the FSM SHALL be in SEARCH.
- Counters clear; the CRC register holds 0xFFFF.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame.
- No FrameDone is issued for it.
- Monitoring resumes via SEARCH.

Configuration
REQ-028 With macro LCD_TIMING_MONITOR_CRC_EN defined, the block SHALL compute the CRC.
- Algorithm: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, no reflection, no final XOR.
- Input: one 16-bit word {R,G,B} per DE=1 cycle, MSB first, single cycle per word.
- The CRC register reinitialises at frame start.
- PixelCrc loads with FrameDone.
REQ-029 Without the macro, PixelCrc SHALL be constant 0 and no CRC logic is instantiated.

Verification
REQ-030 Reset, then 3 frames of 272 lines x (480 DE-high + 45 DE-low), with 12 x 525 DE-low cycles of vertical blank -> FrameDone x2 (first frame absorbed by SEARCH) with HActive=480, VActive=272, FrameErr=0; Locked=1 after the 2nd pulse.
REQ-031 While locked, one line of 481 pixels -> that frame's FrameDone has FrameErr=1 and Locked=0 in the same cycle; two further good frames -> Locked=1.
REQ-032 Frame of 271 lines -> VActive=271, FrameErr=1; FrameCount wraps 255 -> 0 on the 256th pulse.
REQ-033 nRST pulsed low for 3 cycles mid-line -> outputs 0 immediately; no FrameDone until one full vertical gap and one complete frame have followed.
REQ-034 CRC_EN defined, constant pixel 16'hFFFF for a 480x272 frame -> PixelCrc equals a software CCITT model; with the macro undefined, PixelCrc=0.
REQ-035 DE held high for 70000 cycles -> pixel counter saturates; HActive=0xFFFF at the next frame end; FrameErr=1.

Source files
------------

// File: rtl/lcd_timing_monitor_if.sv
// ---------------------------------------------------------------------------
// lcd_timing_monitor_if
// Bundles the SYNC-DE video input and the timing/status results of
// lcd_timing_monitor.
//   master : the video source / observer (drives DE and colour, reads results)
//   slave  : the monitor itself (reads DE and colour, drives results)
// Signals:
//   LCD_DE      data enable of the incoming stream
//   LCD_R/G/B   5/6/5 pixel colour, meaningful only while LCD_DE=1
//   HActive     DE-high width of the last line of the most recent frame
//   VActive     line count of the most recent frame
//   FrameDone   one-cycle pulse at each detected frame end
//   FrameErr    one-cycle pulse with FrameDone when the frame is bad
//   Locked      level, timing matches the expected geometry
//   FrameCount  FrameDone pulses since reset (wraps)
//   PixelCrc    CRC-16-CCITT of the most recent frame's active pixels
// ---------------------------------------------------------------------------
interface lcd_timing_monitor_if;
    logic        LCD_DE;
    logic [4:0]  LCD_R;
    logic [5:0]  LCD_G;
    logic [4:0]  LCD_B;
    logic [15:0] HActive;
    logic [15:0] VActive;
    logic        FrameDone;
    logic        FrameErr;
    logic        Locked;
    logic [7:0]  FrameCount;
    logic [15:0] PixelCrc;

    modport master (
        output LCD_DE, LCD_R, LCD_G, LCD_B,
        input  HActive, VActive, FrameDone, FrameErr, Locked, FrameCount, PixelCrc
    );

    modport slave (
        input  LCD_DE, LCD_R, LCD_G, LCD_B,
        output HActive, VActive, FrameDone, FrameErr, Locked, FrameCount, PixelCrc
    );
endinterface

// File: rtl/lcd_timing_monitor.sv
// ---------------------------------------------------------------------------
// lcd_timing_monitor
// Watches a SYNC-DE video stream, measures line width and line count of each
// frame, flags frames that differ from the expected geometry and reports
// lock once LOCK_FRAMES consecutive good frames have been seen.
// Frame boundaries are found purely from DE: a DE-low run of VGAP_MIN
// cycles is vertical blanking, anything shorter is horizontal blanking.
//
// Ports:
//   PixelClk  pixel clock, all state changes on its rising edge
//   nRST      asynchronous active-low reset
//   bus       lcd_timing_monitor_if.slave (video in, results out)
//
// Optional feature macro: LCD_TIMING_MONITOR_CRC_EN
//   defined   -> PixelCrc carries CRC-16-CCITT (poly 0x1021, init 0xFFFF,
//                no reflection, no final XOR) of {R,G,B} per active pixel
//   undefined -> PixelCrc is tied to 0 and no CRC logic exists
// ---------------------------------------------------------------------------
module lcd_timing_monitor #(
    parameter int EXP_H       = 480,
    parameter int EXP_V       = 272,
    parameter int VGAP_MIN    = 1000,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                PixelClk,
    input  logic                nRST,
    lcd_timing_monitor_if.slave bus
);
    localparam int GAP_W  = $clog2(VGAP_MIN + 1);
    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {SEARCH, V_BLANK, LINE, H_BLANK} state_t;

    state_t            r_state;
    logic [GAP_W-1:0]  r_gap;
    logic [15:0]       r_pix;
    logic [15:0]       r_width;
    logic [15:0]       r_lines;
    logic              r_mismatch;
    logic [GOOD_W-1:0] r_good;

    logic [15:0]       r_hactive;
    logic [15:0]       r_vactive;
    logic              r_frame_done;
    logic              r_frame_err;
    logic              r_locked;
    logic [7:0]        r_frame_count;

    // The DE-low sample that brings the gap counter to VGAP_MIN.
    logic              w_gap_done;
    logic              w_frame_good;
    logic [GOOD_W-1:0] w_good_next;

    assign w_gap_done   = !bus.LCD_DE && (r_gap == GAP_W'(VGAP_MIN - 1));
    assign w_frame_good = (r_lines == 16'(EXP_V)) && !r_mismatch;
    assign w_good_next  = !w_frame_good ? '0 :
                          (r_good == GOOD_W'(LOCK_FRAMES)) ? r_good : r_good + 1'b1;

    // Gap counter runs in every state so SEARCH can find the first vertical gap.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_gap <= '0;
        end else if (bus.LCD_DE) begin
            r_gap <= '0;
        end else if (r_gap != GAP_W'(VGAP_MIN)) begin
            r_gap <= r_gap + 1'b1;
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_state       <= SEARCH;
            r_pix         <= '0;
            r_width       <= '0;
            r_lines       <= '0;
            r_mismatch    <= 1'b0;
            r_good        <= '0;
            r_hactive     <= '0;
            r_vactive     <= '0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                SEARCH: begin
                    // Whatever was in flight is discarded; only a full
                    // vertical gap gives a trustworthy frame start.
                    if (w_gap_done) r_state <= V_BLANK;
                end
                V_BLANK: begin
                    if (bus.LCD_DE) begin
                        r_state    <= LINE;
                        r_pix      <= 16'd1;
                        r_lines    <= 16'd1;
                        r_mismatch <= 1'b0;
                    end
                end
                LINE: begin
                    if (bus.LCD_DE) begin
                        if (r_pix != 16'hFFFF) r_pix <= r_pix + 16'd1;
                    end else begin
                        r_state <= H_BLANK;
                        r_width <= r_pix;
                        if (r_pix != 16'(EXP_H)) r_mismatch <= 1'b1;
                    end
                end
                H_BLANK: begin
                    if (bus.LCD_DE) begin
                        r_state <= LINE;
                        r_pix   <= 16'd1;
                        if (r_lines != 16'hFFFF) r_lines <= r_lines + 16'd1;
                    end else if (w_gap_done) begin
                        r_state       <= V_BLANK;
                        r_frame_done  <= 1'b1;
                        r_frame_err   <= !w_frame_good;
                        r_hactive     <= r_width;
                        r_vactive     <= r_lines;
                        r_frame_count <= r_frame_count + 8'd1;
                        r_good        <= w_good_next;
                        // Uses the next count so Locked drops in the same
                        // cycle as the first bad FrameDone.
                        r_locked      <= (w_good_next == GOOD_W'(LOCK_FRAMES));
                    end
                end
                default: r_state <= SEARCH;
            endcase
        end
    end

    assign bus.HActive    = r_hactive;
    assign bus.VActive    = r_vactive;
    assign bus.FrameDone  = r_frame_done;
    assign bus.FrameErr   = r_frame_err;
    assign bus.Locked     = r_locked;
    assign bus.FrameCount = r_frame_count;

`ifdef LCD_TIMING_MONITOR_CRC_EN
    logic [15:0] w_pixel;
    logic [15:0] r_crc;
    logic [15:0] r_pixel_crc;

    assign w_pixel = {bus.LCD_R, bus.LCD_G, bus.LCD_B};

    // Whole 16-bit word folded in one cycle: with data width equal to the
    // CRC width, XOR-ing the word in first and then shifting 16 times is
    // identical to feeding the bits MSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] crc,
                                             input logic [15:0] data);
        logic [15:0] c;
        c = crc ^ data;
        for (int i = 0; i < 16; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_crc       <= 16'hFFFF;
            r_pixel_crc <= '0;
        end else begin
            if (r_state == V_BLANK && bus.LCD_DE) begin
                r_crc <= crc_step(16'hFFFF, w_pixel);
            end else if ((r_state == LINE || r_state == H_BLANK) && bus.LCD_DE) begin
                r_crc <= crc_step(r_crc, w_pixel);
            end
            if (r_state == H_BLANK && w_gap_done) r_pixel_crc <= r_crc;
        end
    end

    assign bus.PixelCrc = r_pixel_crc;
`else
    // Colour inputs have no consumer in this build.
    logic w_unused_pixel;
    assign w_unused_pixel = ^{bus.LCD_R, bus.LCD_G, bus.LCD_B};
    assign bus.PixelCrc   = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_timing_monitor.sv
module tb_lcd_timing_monitor;
    localparam int EXP_H = 8;
    localparam int EXP_V = 4;
    localparam int VGAP  = 20;
    localparam int LOCKF = 2;
    localparam int HBL   = 3;
    localparam int VBL   = 30;

    typedef struct {
        logic [15:0] h;
        logic [15:0] v;
        logic        err;
        logic        locked;
        logic [7:0]  cnt;
        logic [15:0] crc;
    } exp_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    lcd_timing_monitor_if bus ();

    lcd_timing_monitor #(
        .EXP_H      (EXP_H),
        .EXP_V      (EXP_V),
        .VGAP_MIN   (VGAP),
        .LOCK_FRAMES(LOCKF)
    ) dut (
        .PixelClk(clk),
        .nRST    (nrst),
        .bus     (bus.slave)
    );

    int          total = 0;
    int          bad   = 0;
    exp_t        q[$];
    exp_t        mon_e;
    int          m_count = 0;
    int          m_good  = 0;
    int          frame_no = 0;
    logic [15:0] m_crc = 16'hFFFF;

    // Reference CRC: plain bit-serial CCITT, data MSB first.
    function automatic logic [15:0] crc_model(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.LCD_DE = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drive_pix(input logic [15:0] w);
        bus.LCD_DE = 1'b1;
        {bus.LCD_R, bus.LCD_G, bus.LCD_B} = w;
        m_crc = crc_model(m_crc, w);
        tick();
    endtask

    task automatic push_expect(input int h, input int v, input bit err);
        exp_t e;
        m_count = (m_count + 1) % 256;
        if (err) m_good = 0;
        else if (m_good < LOCKF) m_good++;
        e.h      = 16'(h);
        e.v      = 16'(v);
        e.err    = err;
        e.locked = (m_good == LOCKF);
        e.cnt    = 8'(m_count);
`ifdef LCD_TIMING_MONITOR_CRC_EN
        e.crc    = m_crc;
`else
        e.crc    = 16'h0000;
`endif
        q.push_back(e);
    endtask

    // One frame: nlines lines of 'width' pixels (line odd_line uses odd_width),
    // HBL-cycle horizontal blanks, then vgap DE-low cycles.
    task automatic send_frame(input int nlines, input int width, input int odd_line,
                              input int odd_width, input bit cpix, input bit expect_done,
                              input int vgap);
        int w;
        int last_w;
        bit err;
        m_crc  = 16'hFFFF;
        err    = (nlines != EXP_V);
        last_w = 0;
        for (int l = 0; l < nlines; l++) begin
            w = (l == odd_line) ? odd_width : width;
            if (w != EXP_H) err = 1'b1;
            for (int p = 0; p < w; p++)
                drive_pix(cpix ? 16'hFFFF : 16'((l * 37 + p * 11 + frame_no * 5) & 16'hFFFF));
            last_w = w;
            if (l < nlines - 1) idle(HBL);
        end
        if (expect_done) push_expect((last_w > 65535) ? 65535 : last_w, nlines, err);
        frame_no++;
        idle(vgap);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_HActive"},    32'(bus.HActive),    32'h0);
        chk({tag, "_VActive"},    32'(bus.VActive),    32'h0);
        chk({tag, "_FrameDone"},  32'(bus.FrameDone),  32'h0);
        chk({tag, "_FrameErr"},   32'(bus.FrameErr),   32'h0);
        chk({tag, "_Locked"},     32'(bus.Locked),     32'h0);
        chk({tag, "_FrameCount"}, 32'(bus.FrameCount), 32'h0);
        chk({tag, "_PixelCrc"},   32'(bus.PixelCrc),   32'h0);
    endtask

    // Scoreboard monitor: every FrameDone must match the oldest expectation.
    always @(negedge clk) begin
        if (nrst && bus.FrameDone) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got FrameDone=1 (FrameCount=%0d), want no pulse",
                         bus.FrameCount);
            end else begin
                mon_e = q.pop_front();
                chk("HActive",    32'(bus.HActive),    32'(mon_e.h));
                chk("VActive",    32'(bus.VActive),    32'(mon_e.v));
                chk("FrameErr",   32'(bus.FrameErr),   32'(mon_e.err));
                chk("Locked",     32'(bus.Locked),     32'(mon_e.locked));
                chk("FrameCount", 32'(bus.FrameCount), 32'(mon_e.cnt));
                chk("PixelCrc",   32'(bus.PixelCrc),   32'(mon_e.crc));
                $display("frame cnt=%0d H=%0d V=%0d err=%0b locked=%0b crc=%04h",
                         bus.FrameCount, bus.HActive, bus.VActive, bus.FrameErr,
                         bus.Locked, bus.PixelCrc);
            end
        end
    end

    initial begin
        bus.LCD_DE = 1'b0;
        bus.LCD_R  = '0;
        bus.LCD_G  = '0;
        bus.LCD_B  = '0;
        repeat (3) tick();
        check_zero("reset");
        nrst = 1'b1;
        idle(2);

        // First frame only synchronises; the next two are reported.
        send_frame(EXP_V, EXP_H, -1, 0, 1'b0, 1'b0, VBL);
        send_frame(EXP_V, EXP_H, -1, 0, 1'b0, 1'b1, VBL);
        send_frame(EXP_V, EXP_H, -1, 0, 1'b1, 1'b1, VBL);   // constant 0xFFFF pixels

        // One over-wide line while locked, then recovery.
        send_frame(EXP_V, EXP_H, 1, EXP_H + 1, 1'b0, 1'b1, VBL);
        send_frame(EXP_V, EXP_H, -1, 0, 1'b0, 1'b1, VBL);
        send_frame(EXP_V, EXP_H, -1, 0, 1'b0, 1'b1, VBL);

        // Short frame.
        send_frame(EXP_V - 1, EXP_H, -1, 0, 1'b0, 1'b1, VBL);

        // DE stuck high: pixel counter saturates.
        send_frame(1, 65540, -1, 0, 1'b0, 1'b1, VBL);

        // Reset mid-line discards the partial frame.
        for (int p = 0; p < EXP_H; p++) drive_pix(16'h1234);
        idle(HBL);
        for (int p = 0; p < 4; p++) drive_pix(16'h4321);
        nrst = 1'b0;
        #1;
        check_zero("rst_mid");
        repeat (3) tick();
        nrst    = 1'b1;
        m_count = 0;
        m_good  = 0;
        for (int p = 0; p < 4; p++) drive_pix(16'h5555);
        idle(HBL);
        for (int p = 0; p < EXP_H; p++) drive_pix(16'hAAAA);
        idle(VBL);
        send_frame(EXP_V, EXP_H, -1, 0, 1'b0, 1'b1, VBL);

        // Tiny bad frames to walk FrameCount through 255 -> 0.
        for (int f = 0; f < 256; f++)
            send_frame(1, 1, -1, 0, 1'b0, 1'b1, VGAP + 1);

        idle(5);
        chk("pending_expectations", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
